fc2_score_sender: RTL and testbench

FC2_SCORE_SENDER -- requirements
Module: fc2_score_sender

---
 rtl/fc2_score_sender_pkg.sv | 18 +
 rtl/fc2_score_bias_sat.sv | 45 ++++
 rtl/fc2_score_sender.sv | 115 +++++++++++
 tb/tb_fc2_score_sender.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fc2_score_sender_pkg.sv
// rtl/fc2_score_sender_pkg.sv - shared types and constants for the FC2 score sender
package fc2_score_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int DATA_W_DEF      = 32;

    // Saturation limits of the biased-score adder at the default width
    localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/fc2_score_bias_sat.sv
// rtl/fc2_score_bias_sat.sv - per-class bias registers and saturating score adder
module fc2_score_bias_sat
    import fc2_score_sender_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bias_wr_en,
    input  logic [3:0]        bias_addr,
    input  logic [DATA_W-1:0] bias_data,
    input  logic [3:0]        rd_tag,
    input  logic [DATA_W-1:0] score_in,
    output logic [DATA_W-1:0] score_out
);

    localparam logic [4:0]        NC     = 5'(NUM_CLASSES);
    localparam logic [DATA_W-1:0] MAX_V  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] bias [NUM_CLASSES];
    logic [DATA_W-1:0] bias_sel;
    logic [DATA_W:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) bias[i] <= '0;
        end else if (bias_wr_en && ({1'b0, bias_addr} < NC)) begin
            bias[bias_addr] <= bias_data;
        end
    end

    assign bias_sel = bias[rd_tag];
    assign sum      = {score_in[DATA_W-1], score_in} + {bias_sel[DATA_W-1], bias_sel};

    // Sign bits disagreeing means the true sum left the DATA_W range
    always_comb begin
        score_out = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            score_out = sum[DATA_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fc2_score_sender.sv
// rtl/fc2_score_sender.sv - collects FC2 class scores and streams them in tag order; FC2_SCORE_BIAS_EN adds saturating bias
module fc2_score_sender
    import fc2_score_sender_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef FC2_SCORE_BIAS_EN
    input  logic              bias_wr_en,
    input  logic [3:0]        bias_addr,
    input  logic [DATA_W-1:0] bias_data,
`endif
    output logic              score_en,
    output logic [DATA_W-1:0] score_data,
    output logic [3:0]        score_tag,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam logic [4:0]             NC       = 5'(NUM_CLASSES);
    localparam logic [3:0]             LAST_TAG = 4'(NUM_CLASSES - 1);
    localparam logic [NUM_CLASSES-1:0] ALL_SET  = '1;

    state_t                 state, state_nxt;
    logic [NUM_CLASSES-1:0] mask, mask_nxt;
    logic [DATA_W-1:0]      scores [NUM_CLASSES];
    logic [3:0]             tag_cnt;
    logic [DATA_W-1:0]      send_data;
    logic                   addr_ok, wr_ok, wr_bad;

    assign addr_ok = ({1'b0, wr_addr} < NC);
    assign wr_ok   = (state == ST_COLLECT) && wr_en && addr_ok;
    assign wr_bad  = (state == ST_COLLECT) && wr_en && !addr_ok;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        mask_nxt = mask;
        if (wr_ok) mask_nxt[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The mask-completing write is stored on the same edge that moves to SEND
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_COLLECT;
            ST_COLLECT: if (mask_nxt == ALL_SET) state_nxt = ST_SEND;
            ST_SEND:    if (tag_cnt == LAST_TAG) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

`ifdef FC2_SCORE_BIAS_EN
    fc2_score_bias_sat #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_W      (DATA_W)
    ) u_bias_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bias_wr_en (bias_wr_en),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .rd_tag     (tag_cnt),
        .score_in   (scores[tag_cnt]),
        .score_out  (send_data)
    );
`else
    assign send_data = scores[tag_cnt];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask       <= '0;
            tag_cnt    <= '0;
            score_en   <= 1'b0;
            score_data <= '0;
            score_tag  <= '0;
            done       <= 1'b0;
            addr_err   <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) scores[i] <= '0;
        end else begin
            done       <= (state == ST_DONE);
            score_en   <= 1'b0;
            score_data <= '0;
            score_tag  <= '0;
            if ((state == ST_IDLE) && start) begin
                mask     <= '0;
                addr_err <= 1'b0;
            end else begin
                mask <= mask_nxt;
            end
            if (wr_ok)  scores[wr_addr] <= wr_data;
            if (wr_bad) addr_err <= 1'b1;
            if (state == ST_SEND) begin
                score_en   <= 1'b1;
                score_data <= send_data;
                score_tag  <= tag_cnt;
                tag_cnt    <= (tag_cnt == LAST_TAG) ? 4'd0 : tag_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fc2_score_sender.sv
// tb/tb_fc2_score_sender.sv - directed self-checking bench for fc2_score_sender (bias checks under FC2_SCORE_BIAS_EN)
module tb_fc2_score_sender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
`ifdef FC2_SCORE_BIAS_EN
    logic        bias_wr_en = 1'b0;
    logic [3:0]  bias_addr = '0;
    logic [31:0] bias_data = '0;
`endif
    logic        score_en;
    logic [31:0] score_data;
    logic [3:0]  score_tag;
    logic        busy;
    logic        done;
    logic        addr_err;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          amax;
    logic [31:0] exp_s [10];

    fc2_score_sender #(
        .NUM_CLASSES (10),
        .DATA_W      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef FC2_SCORE_BIAS_EN
        .bias_wr_en (bias_wr_en),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
`endif
        .score_en   (score_en),
        .score_data (score_data),
        .score_tag  (score_tag),
        .busy       (busy),
        .done       (done),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after the mask-completing write; pulses start at tag start_at if >= 0
    task automatic send_check(input int start_at, output int arg_max);
        logic signed [31:0] best;
        chk("latency_gap", {busy, score_en}, 2'b10);
        @(negedge clk);
        best    = 32'sh80000000;
        arg_max = -1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("score_tag%0d", i), {done, score_en, score_tag, score_data},
                {1'b0, 1'b1, 4'(i), exp_s[i]});
            if (arg_max < 0 || $signed(score_data) > best) begin
                best    = $signed(score_data);
                arg_max = int'(score_tag);
            end
            if (i == start_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", {done, busy, score_en, score_tag, score_data}, {3'b100, 4'd0, 32'd0});
        @(negedge clk);
        chk("done_clear", {done, busy}, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {score_en, score_data, score_tag, busy, done, addr_err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // In-order frame, class 7 is the peak
        pulse_start();
        chk("start_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) exp_s[i] = (i == 7) ? 32'd500 : 32'(10 * i);
        for (int i = 0; i < 10; i++) wr(i, exp_s[i]);
        send_check(-1, amax);
        chk("argmax", amax, 7);

        // Scrambled order with a duplicate on class 3
        pulse_start();
        for (int i = 0; i < 10; i++) exp_s[i] = 32'(100 + i);
        exp_s[3] = 32'hFFFF_FFFE;
        wr(9, exp_s[9]);
        wr(3, 32'd5);
        wr(0, exp_s[0]);
        wr(1, exp_s[1]);
        wr(2, exp_s[2]);
        wr(3, 32'hFFFF_FFFE);
        for (int i = 4; i < 8; i++) wr(i, exp_s[i]);
        @(negedge clk);
        chk("dup_no_send", {busy, score_en}, 2'b10);
        wr(8, exp_s[8]);
        send_check(-1, amax);

        // Out-of-range address and writes outside COLLECT
        wr(12, 32'hDEAD);
        wr(0, 32'h1234);
        chk("idle_wr_ignored", {busy, addr_err, score_en}, 3'b000);
        pulse_start();
        for (int i = 0; i < 10; i++) exp_s[i] = 32'(3 * i + 1);
        for (int i = 0; i < 5; i++) wr(i, exp_s[i]);
        wr(12, 32'hBAD);
        chk("addr_err_set", addr_err, 1'b1);
        for (int i = 5; i < 9; i++) wr(i, exp_s[i]);
        @(negedge clk);
        chk("bad_addr_no_mask", {busy, score_en}, 2'b10);
        wr(9, exp_s[9]);
        send_check(-1, amax);
        chk("addr_err_sticky", addr_err, 1'b1);
        pulse_start();
        chk("addr_err_cleared", {busy, addr_err}, 2'b10);

        // Start pulse mid-SEND must not disturb the frame
        for (int i = 0; i < 10; i++) exp_s[i] = 32'(i * i - 20);
        for (int i = 0; i < 10; i++) wr(i, exp_s[i]);
        send_check(4, amax);
        @(negedge clk);
        chk("start_in_send_ignored", {busy, score_en}, 2'b00);

        // Reset at tag 5 aborts at once
        pulse_start();
        for (int i = 0; i < 10; i++) exp_s[i] = 32'(1000 + i);
        for (int i = 0; i < 10; i++) wr(i, exp_s[i]);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("pre_reset_tag%0d", i), {score_en, score_tag, score_data},
                {1'b1, 4'(i), exp_s[i]});
            if (i < 5) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("reset_abort", {score_en, busy, done, score_tag, score_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 10; i++) exp_s[i] = 32'(50 - i);
        for (int i = 9; i >= 0; i--) wr(i, exp_s[i]);
        send_check(-1, amax);

`ifdef FC2_SCORE_BIAS_EN
        bias_wr_en = 1'b1;
        bias_addr = 4'd2; bias_data = 32'd100;
        @(negedge clk);
        bias_addr = 4'd4; bias_data = 32'hFFFF_FFF6;
        @(negedge clk);
        bias_addr = 4'd1; bias_data = 32'd7;
        @(negedge clk);
        bias_wr_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) exp_s[i] = 32'd0;
        exp_s[1] = 32'd10;
        exp_s[2] = 32'h7FFF_FFFF;
        exp_s[4] = 32'h8000_0000;
        wr(0, 32'd0);
        wr(1, 32'd3);
        wr(2, 32'h7FFF_FFF0);
        wr(3, 32'd0);
        wr(4, 32'h8000_0004);
        for (int i = 5; i < 10; i++) wr(i, 32'd0);
        send_check(-1, amax);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
